rob_unit: RTL

ROB_UNIT -- requirements
Module: rob_unit

---
 rtl/rob_unit_if.sv | 64 ++++++
 rtl/rob_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rob_unit_if.sv
// Bundle of the reorder buffer's dispatch, writeback, lookup, commit and status signals.
// The flush input only exists when ROB_FLUSH_EN is defined.
interface rob_unit_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
);
    localparam int TAG_W = $clog2(DEPTH);

`ifdef ROB_FLUSH_EN
    logic              flush;
`endif
    logic              alloc_valid;
    logic [OP_W-1:0]   alloc_opcode;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic [TAG_W-1:0]  lookup_tag;
    logic              lookup_done;
    logic [DATA_W-1:0] lookup_value;
    logic              commit_valid;
    logic              commit_ready;
    logic [OP_W-1:0]   commit_opcode;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_value;
    logic              commit_we;
    logic              full;
    logic              empty;
    logic [TAG_W:0]    count;

    modport slave (
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  alloc_valid, alloc_opcode, alloc_dest,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_value,
        input  lookup_tag,
        output lookup_done, lookup_value,
        output commit_valid,
        input  commit_ready,
        output commit_opcode, commit_dest, commit_value, commit_we,
        output full, empty, count
    );

    modport master (
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output alloc_valid, alloc_opcode, alloc_dest,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_value,
        output lookup_tag,
        input  lookup_done, lookup_value,
        input  commit_valid,
        output commit_ready,
        input  commit_opcode, commit_dest, commit_value, commit_we,
        input  full, empty, count
    );
endinterface

// File: rtl/rob_unit.sv
// Circular reorder buffer: in-order allocate and retire, out-of-order result writeback.
// Optional feature macro ROB_FLUSH_EN adds a flush input that empties the buffer.
module rob_unit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rob_unit_if.slave  bus
);
    localparam int               TAG_W    = $clog2(DEPTH);
    localparam logic [OP_W-1:0]  OP_STORE = OP_W'(4'b0100);
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [OP_W-1:0]   r_opcode [DEPTH];
    logic [REG_W-1:0]  r_dest   [DEPTH];
    logic [DATA_W-1:0] r_value  [DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_alloc;
    logic              w_commit_valid;
    logic              w_commit;
    logic              w_wb_ok;
    logic [DEPTH-1:0]  w_alloc_sel;
    logic [DEPTH-1:0]  w_commit_sel;
    logic [DEPTH-1:0]  w_wb_sel;

`ifdef ROB_FLUSH_EN
    logic w_flush;
    assign w_flush = bus.flush;
`endif

    assign w_full         = (r_count == CNT_FULL);
    assign w_empty        = (r_count == '0);
    // Full blocks allocation outright, even when the head retires this cycle.
    assign w_alloc        = bus.alloc_valid && !w_full;
    assign w_commit_valid = !w_empty && r_done[r_head];
    assign w_commit       = w_commit_valid && bus.commit_ready;
    assign w_wb_ok        = bus.wb_valid && r_busy[bus.wb_tag];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign w_alloc_sel[gi]  = w_alloc  && (r_tail      == TAG_W'(gi));
            assign w_commit_sel[gi] = w_commit && (r_head      == TAG_W'(gi));
            assign w_wb_sel[gi]     = w_wb_ok  && (bus.wb_tag  == TAG_W'(gi));
        end
    endgenerate

    // A retiring entry ignores a same-cycle writeback; alloc and wb never hit the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_done <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_opcode[i] <= '0;
                r_dest[i]   <= '0;
                r_value[i]  <= '0;
            end
        end
`ifdef ROB_FLUSH_EN
        else if (w_flush) begin
            r_busy <= '0;
            r_done <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_opcode[i] <= '0;
                r_dest[i]   <= '0;
                r_value[i]  <= '0;
            end
        end
`endif
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_commit_sel[i]) begin
                    r_busy[i] <= 1'b0;
                    r_done[i] <= 1'b0;
                end else if (w_alloc_sel[i]) begin
                    r_busy[i]   <= 1'b1;
                    r_done[i]   <= 1'b0;
                    r_opcode[i] <= bus.alloc_opcode;
                    r_dest[i]   <= bus.alloc_dest;
                end else if (w_wb_sel[i]) begin
                    r_done[i]  <= 1'b1;
                    r_value[i] <= bus.wb_value;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end
`endif
        else begin
            if (w_alloc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_commit) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.alloc_ready   = !w_full;
    assign bus.alloc_tag     = r_tail;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.count         = r_count;
    assign bus.commit_valid  = w_commit_valid;
    assign bus.commit_opcode = r_opcode[r_head];
    assign bus.commit_dest   = r_dest[r_head];
    assign bus.commit_value  = r_value[r_head];
    // Gated by occupancy so an empty buffer never requests a register write.
    assign bus.commit_we     = r_busy[r_head] && (r_opcode[r_head] != OP_STORE);
    assign bus.lookup_done   = r_busy[bus.lookup_tag] && r_done[bus.lookup_tag];
    assign bus.lookup_value  = r_value[bus.lookup_tag];
endmodule
